// File: rtl/runlight_mode_ctrl.sv
// runlight_mode_ctrl: key debounce, short/long press detection, mode select and step pacing
//   for the run-light pattern engine.
// Latency: clean key edge -> key_level in 2+DEBOUNCE_CYCLES cycles; press action -> S one edge later.
// Backpressure: none; S/mode_chg/step_tick are free-running outputs consumed by the engine.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   key_in     raw bouncy push-button (1 = pressed), asynchronous to clk
//   mode_set   synchronous host load strobe, highest priority
//   mode_val   mode code loaded with mode_set (accepted if < NUM_MODES or == PARK_CODE)
//   S          registered pattern-select code
//   mode_chg   one-cycle pulse in the first cycle S holds a new value
//   step_tick  one-cycle step enable, every STEP_DIV cycles, held 0 while parked
//   key_level  debounced key level
module runlight_mode_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 20,
  parameter int         LONG_CYCLES     = 1000,
  parameter int         STEP_DIV        = 50,
  parameter int         NUM_MODES       = 4,
  parameter logic [2:0] PARK_CODE       = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  input  logic       mode_set,
  input  logic [2:0] mode_val,
  output logic [2:0] S,
  output logic       mode_chg,
  output logic       step_tick,
  output logic       key_level
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int DIV_W  = $clog2(STEP_DIV);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [2:0]        LAST_MODE = 3'(NUM_MODES - 1);
  localparam logic [3:0]        NUM_MODES_L = 4'(NUM_MODES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic [DB_W-1:0]   r_db_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [DIV_W-1:0]  r_div;
  logic              w_short;
  logic              w_long;
  logic              w_load_ok;
  logic [2:0]        w_s_nxt;
  logic              w_s_change;

  // Two-flop synchronizer; only r_sync2 is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_cnt  <= '0;
      key_level <= 1'b0;
    end else if (r_sync2 != key_level) begin
      if (r_db_cnt == DB_LAST) begin
        r_db_cnt  <= '0;
        key_level <= r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Press FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Press FSM: next state. IDLE is only ever entered with key_level low, so a
  // high level seen in IDLE is the 0->1 edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (key_level) w_state_nxt = HELD;
      HELD:    if (!key_level)               w_state_nxt = IDLE;
               else if (r_hold == HOLD_LAST) w_state_nxt = LONG;
      LONG:    if (!key_level) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Press FSM: outputs (press actions happen on the transition edge).
  always_comb begin
    w_short = 1'b0;
    w_long  = 1'b0;
    if (r_state == HELD) begin
      w_short = !key_level;
      w_long  = key_level && (r_hold == HOLD_LAST);
    end
  end

  // Hold counter: zero outside HELD, so it starts at 0 on HELD entry; saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_hold <= '0;
    else if (r_state != HELD)  r_hold <= '0;
    else if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
  end

  // Next mode: host load overrides any press action; invalid loads act as no load.
  assign w_load_ok = mode_set && (({1'b0, mode_val} < NUM_MODES_L) || (mode_val == PARK_CODE));

  always_comb begin
    w_s_nxt = S;
    if (w_short) begin
      if ((S == PARK_CODE) || (S == LAST_MODE)) w_s_nxt = 3'd0;
      else                                      w_s_nxt = S + 3'd1;
    end else if (w_long) begin
      w_s_nxt = PARK_CODE;
    end
    if (w_load_ok) w_s_nxt = mode_val;
  end

  assign w_s_change = (w_s_nxt != S);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      S        <= 3'd0;
      mode_chg <= 1'b0;
    end else begin
      S        <= w_s_nxt;
      mode_chg <= w_s_change;
    end
  end

  // Step divider. Held at 0 on the change edge and through the mode_chg cycle,
  // so the first tick lands STEP_DIV cycles after mode_chg. Parked: held at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       r_div <= '0;
    else if (w_s_change || mode_chg || (S == PARK_CODE)) r_div <= '0;
    else if (r_div == DIV_LAST)                       r_div <= '0;
    else                                              r_div <= r_div + 1'b1;
  end

  assign step_tick = (r_div == DIV_LAST) && (S != PARK_CODE);

endmodule

// File: doc/runlight_mode_ctrl.md
Name: runlight_mode_ctrl

Overview:
- Upstream front end for the run-light pattern engine. Takes one raw push-button and an optional host load, and produces the pattern-select code S[2:0] that the engine consumes.
- Also produces a step-enable tick that paces the pattern.
- Debounces the key, separates short and long presses, cycles through modes on short presses, and parks the engine on a long press.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable synchronized samples required to accept a key level change (>=2).
- LONG_CYCLES, 1000: debounced-press duration, in cycles, at which a press becomes a long press (>DEBOUNCE_CYCLES).
- STEP_DIV, 50: step_tick period in cycles (>=2).
- NUM_MODES, 4: number of active pattern modes, codes 0..NUM_MODES-1 (<=7).
- PARK_CODE, 3'd4: S value that parks the engine (must be >=NUM_MODES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- key_in  in  1  raw button, 1 = pressed, asynchronous to clk, bouncy
- mode_set  in  1  synchronous host load strobe
- mode_val  in  3  mode code loaded when mode_set=1
- S  out  3  registered mode select to the pattern engine
- mode_chg  out  1  one-cycle pulse in the first cycle S shows a new value
- step_tick  out  1  one-cycle step enable
- key_level  out  1  debounced key level (observability)

Behaviour:
- Reset (reset=0, async):
  - Outputs: S=0, mode_chg=0, step_tick=0, key_level=0.
  - Internal: synchronizer=0, debounce count=0, FSM=IDLE, divider=0.
  - Release is sampled on clk. Reset asserted mid-press aborts the press; no mode change occurs.
- Synchronizer: 2-flop on key_in. Debounce then runs on the second flop only.
- Debounce:
  - When sync != key_level, the counter increments.
  - When the count reaches DEBOUNCE_CYCLES-1 with sync still different, key_level flips on the next edge and the counter clears.
  - Any cycle with sync == key_level clears the counter. Glitches shorter than DEBOUNCE_CYCLES are never seen.
- Press FSM (hold counter is saturating, width ceil(log2(LONG_CYCLES+1))):
  - IDLE: on key_level 0->1, go to HELD and set hold=0.
  - HELD: hold increments each cycle.
    - If key_level goes 0 first: short press, return to IDLE.
    - If hold reaches LONG_CYCLES-1 with key still 1: go to LONG.
  - LONG: wait for key_level 0, then go to IDLE. The release has no effect.
- Short press, applied on the release edge:
  - If S == PARK_CODE, S <= 0.
  - Else if S == NUM_MODES-1, S <= 0 (wrap).
  - Else S <= S+1.
- Long press, applied on entry to LONG: S <= PARK_CODE. If already parked, S is unchanged and mode_chg is not asserted.
- mode_set:
  - Highest priority. If mode_val < NUM_MODES or mode_val == PARK_CODE, S <= mode_val.
  - Other values are ignored: no change, no pulse.
  - A load coinciding with a press action wins. The press action is discarded and the FSM still advances normally.
  - Loading the current value gives no pulse.
- mode_chg: registered; high exactly in the cycle S first holds the new value. Any S change, and only an S change, produces the pulse.
- step_tick:
  - Divider counts 0..STEP_DIV-1 and wraps. step_tick=1 in the cycle the count equals STEP_DIV-1.
  - On any S change the divider resets to 0, so the first tick comes STEP_DIV cycles after mode_chg.
  - While S == PARK_CODE, step_tick is held 0 and the divider is held at 0.
- Latency: key_in edge to key_level change is 2 + DEBOUNCE_CYCLES cycles for a clean edge.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, STEP_DIV=5, NUM_MODES=4, PARK_CODE=4):
- Reset, then idle 20 cycles:
  - S=0, mode_chg never 1.
  - step_tick high at cycles 4, 9, 14, 19 after release.
- Key pulse of 3 cycles, plus 1-cycle bounces:
  - key_level stays 0, S stays 0.
- Clean 8-cycle press, then release:
  - key_level rises 6 cycles after press and falls 6 cycles after release.
  - S goes 0->1 with one mode_chg pulse. The next step_tick comes exactly 5 cycles later.
- Four short presses from S=0:
  - S sequence 1, 2, 3, 0, with four mode_chg pulses.
- 30-cycle hold from S=2:
  - S=4 at HELD+16, single pulse, step_tick stays 0.
  - Release leaves S=4. The next short press gives S=0.
- mode_set=1 with mode_val=5 gives no change. mode_val=3 in the same cycle as a short-press release gives S=3 with one pulse.
- Reset asserted mid-HELD:
  - S=0 immediately.
  - After release, a stuck-high key is accepted as a new press with no spurious mode change.
